// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the priority arbiter
//
// Purpose: arbitration policy and FSM state enums, plus index-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED_MSB,
    ARB_FIXED_LSB,
    ARB_ROUND_ROBIN
  } arb_mode_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular first-set-bit search
//
// Purpose: find the first eligible request at or after start, wrapping
// from N-1 back to 0.
// Ports:
//   req    in  [N]      request vector
//   start  in  [IDX_W]  index where the ascending search begins
//   excl   in  [N]      requests to ignore this cycle
//   idx    out [IDX_W]  winning index (0 when nothing found)
//   found  out          an eligible request exists
module rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     excl,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]     elig;
  logic [N-1:0]     upper;
  logic [IDX_W-1:0] upper_idx;
  logic             upper_found;
  logic [IDX_W-1:0] low_idx;
  logic             low_found;

  // Two-pass search equivalent to a double-width vector: first the
  // eligible bits at or above start, then the full vector as the wrap.
  always_comb begin
    elig        = req & ~excl;
    upper       = '0;
    upper_idx   = '0;
    upper_found = 1'b0;
    low_idx     = '0;
    low_found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      upper[i] = elig[i] && (IDX_W'(i) >= start);
    end
    for (int i = 0; i < N; i++) begin
      if (!upper_found && upper[i]) begin
        upper_found = 1'b1;
        upper_idx   = IDX_W'(i);
      end
      if (!low_found && elig[i]) begin
        low_found = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
    found = low_found;
    idx   = upper_found ? upper_idx : low_idx;
  end

endmodule

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-way request arbiter with valid/ready grant
//
// Purpose: picks one requester (fixed MSB, fixed LSB or round-robin) and
// presents it as a registered grant held until accepted.
// Ports:
//   clk         in              system clock, rising edge
//   reset_n     in              asynchronous active-low reset
//   req         in  [N_REQ]     request vector, bit i = requester i
//   gnt_valid   out             grant presented
//   gnt_ready   in              consumer accepts the grant this cycle
//   gnt_idx     out [IDX_W]     granted index
//   gnt_onehot  out [N_REQ]     one-hot grant, zero when gnt_valid=0
//   rr_ptr      out [IDX_W]     round-robin start index (0 in fixed modes)
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int        N_REQ = 8,
  parameter arb_mode_t MODE  = ARB_ROUND_ROBIN,
  localparam int       IDX_W = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] rr_ptr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0] gnt_onehot_q, gnt_onehot_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_start;
  logic [N_REQ-1:0] pick_excl;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;

  assign accept = (state_q == ARB_GRANT) && gnt_ready;

  // Fixed-MSB reuses the ascending search on a bit-reversed vector.
  always_comb begin
    pick_req   = req;
    pick_start = '0;
    pick_excl  = '0;
    if (MODE == ARB_FIXED_MSB) begin
      for (int i = 0; i < N_REQ; i++) begin
        pick_req[i] = req[N_REQ-1-i];
      end
    end
    if (MODE == ARB_ROUND_ROBIN) begin
      pick_start = rr_ptr_q;
      // The accepted index must not win again on the same edge.
      if (accept) begin
        pick_excl = gnt_onehot_q;
      end
    end
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    win_idx    = (MODE == ARB_FIXED_MSB) ? (LAST_IDX - pick_idx) : pick_idx;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        gnt_onehot_d = '0;
        if (pick_found) begin
          state_d      = ARB_GRANT;
          gnt_idx_d    = win_idx;
          gnt_onehot_d = win_onehot;
        end
      end
      ARB_GRANT: begin
        // Without a handshake the grant is held, never revoked.
        if (gnt_ready) begin
          if (MODE == ARB_ROUND_ROBIN) begin
            rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
          end
          if (pick_found) begin
            gnt_idx_d    = win_idx;
            gnt_onehot_d = win_onehot;
          end else begin
            state_d      = ARB_IDLE;
            gnt_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d      = ARB_IDLE;
        gnt_onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign gnt_valid  = (state_q == ARB_GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - directed self-checking bench for prio_arbiter
module tb_prio_arbiter;
  import arb_pkg::*;

  logic clk;
  logic reset_n;

  logic [7:0] rr_req, msb_req, lsb_req;
  logic       rr_rdy, msb_rdy, lsb_rdy;
  logic       rr_vld, msb_vld, lsb_vld;
  logic [2:0] rr_idx, msb_idx, lsb_idx;
  logic [7:0] rr_oh, msb_oh, lsb_oh;
  logic [2:0] rr_ptr, msb_ptr, lsb_ptr;

  logic [4:0] r5_req;
  logic       r5_rdy, r5_vld;
  logic [2:0] r5_idx, r5_ptr;
  logic [4:0] r5_oh;

  int n_cmp = 0;
  int n_err = 0;

  prio_arbiter #(.N_REQ(8), .MODE(ARB_ROUND_ROBIN)) u_rr (
    .clk(clk), .reset_n(reset_n), .req(rr_req), .gnt_valid(rr_vld),
    .gnt_ready(rr_rdy), .gnt_idx(rr_idx), .gnt_onehot(rr_oh), .rr_ptr(rr_ptr));

  prio_arbiter #(.N_REQ(8), .MODE(ARB_FIXED_MSB)) u_msb (
    .clk(clk), .reset_n(reset_n), .req(msb_req), .gnt_valid(msb_vld),
    .gnt_ready(msb_rdy), .gnt_idx(msb_idx), .gnt_onehot(msb_oh), .rr_ptr(msb_ptr));

  prio_arbiter #(.N_REQ(8), .MODE(ARB_FIXED_LSB)) u_lsb (
    .clk(clk), .reset_n(reset_n), .req(lsb_req), .gnt_valid(lsb_vld),
    .gnt_ready(lsb_rdy), .gnt_idx(lsb_idx), .gnt_onehot(lsb_oh), .rr_ptr(lsb_ptr));

  prio_arbiter #(.N_REQ(5), .MODE(ARB_ROUND_ROBIN)) u_r5 (
    .clk(clk), .reset_n(reset_n), .req(r5_req), .gnt_valid(r5_vld),
    .gnt_ready(r5_rdy), .gnt_idx(r5_idx), .gnt_onehot(r5_oh), .rr_ptr(r5_ptr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rr_req  = 8'hFF; rr_rdy  = 1'b0;
    msb_req = 8'h00; msb_rdy = 1'b0;
    lsb_req = 8'h00; lsb_rdy = 1'b0;
    r5_req  = 5'h00; r5_rdy  = 1'b0;

    // Reset held with all requests asserted.
    repeat (3) tick();
    chk("rst_vld", 32'(rr_vld), 32'd0);
    chk("rst_oh",  32'(rr_oh),  32'h00);
    chk("rst_ptr", 32'(rr_ptr), 32'd0);
    chk("rst_idx", 32'(rr_idx), 32'd0);

    // First grant one cycle after release.
    reset_n = 1'b1;
    tick();
    chk("first_vld", 32'(rr_vld), 32'd1);
    chk("first_idx", 32'(rr_idx), 32'd0);
    chk("first_oh",  32'(rr_oh),  32'h01);

    // Round-robin fairness and wrap, no bubbles.
    rr_rdy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rr_vld_%0d", k), 32'(rr_vld), 32'd1);
      chk($sformatf("rr_idx_%0d", k), 32'(rr_idx), 32'(k % 8));
      chk($sformatf("rr_ptr_%0d", k), 32'(rr_ptr), 32'(k % 8));
      chk($sformatf("rr_oh_%0d", k),  32'(rr_oh),  32'(1 << (k % 8)));
    end

    // Hold stability: index 2 presented, no handshake.
    rr_rdy = 1'b0;
    rr_req = 8'b0000_0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_idx_%0d", k), 32'(rr_idx), 32'd2);
      chk($sformatf("hold_oh_%0d", k),  32'(rr_oh),  32'h04);
    end
    rr_req = 8'h80;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("hold_hi_idx_%0d", k), 32'(rr_idx), 32'd2);
      chk($sformatf("hold_hi_vld_%0d", k), 32'(rr_vld), 32'd1);
    end
    rr_rdy = 1'b1;
    tick();
    chk("next7_idx", 32'(rr_idx), 32'd7);
    chk("next7_ptr", 32'(rr_ptr), 32'd3);
    chk("next7_vld", 32'(rr_vld), 32'd1);

    // Only the just-accepted index requests: drop to idle.
    tick();
    chk("idle_vld", 32'(rr_vld), 32'd0);
    chk("idle_oh",  32'(rr_oh),  32'h00);
    chk("idle_idx", 32'(rr_idx), 32'd7);
    chk("idle_ptr", 32'(rr_ptr), 32'd0);

    // Ready while idle is ignored.
    rr_req = 8'h00;
    tick();
    chk("idle_rdy_vld", 32'(rr_vld), 32'd0);
    chk("idle_rdy_ptr", 32'(rr_ptr), 32'd0);

    // Build up grant index 3 with a non-zero pointer.
    rr_rdy = 1'b0;
    rr_req = 8'b0000_0010;
    tick();
    chk("pre_idx1", 32'(rr_idx), 32'd1);
    rr_req = 8'b0000_1000;
    rr_rdy = 1'b1;
    tick();
    rr_rdy = 1'b0;
    chk("pre_idx3", 32'(rr_idx), 32'd3);
    chk("pre_ptr2", 32'(rr_ptr), 32'd2);
    chk("pre_vld",  32'(rr_vld), 32'd1);

    // Asynchronous reset between edges.
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_vld", 32'(rr_vld), 32'd0);
    chk("arst_oh",  32'(rr_oh),  32'h00);
    chk("arst_ptr", 32'(rr_ptr), 32'd0);
    rr_req = 8'h00;
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_arst_vld", 32'(rr_vld), 32'd0);
    chk("post_arst_ptr", 32'(rr_ptr), 32'd0);

    // Fixed modes and the 5-way round-robin, back-to-back.
    msb_req = 8'b0101_0010; msb_rdy = 1'b1;
    lsb_req = 8'b0101_0010; lsb_rdy = 1'b1;
    r5_req  = 5'b10001;     r5_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("msb_vld_%0d", k), 32'(msb_vld), 32'd1);
      chk($sformatf("msb_idx_%0d", k), 32'(msb_idx), 32'd6);
      chk($sformatf("msb_oh_%0d", k),  32'(msb_oh),  32'h40);
      chk($sformatf("msb_ptr_%0d", k), 32'(msb_ptr), 32'd0);
      chk($sformatf("lsb_vld_%0d", k), 32'(lsb_vld), 32'd1);
      chk($sformatf("lsb_idx_%0d", k), 32'(lsb_idx), 32'd1);
      chk($sformatf("lsb_oh_%0d", k),  32'(lsb_oh),  32'h02);
      chk($sformatf("lsb_ptr_%0d", k), 32'(lsb_ptr), 32'd0);
      chk($sformatf("r5_vld_%0d", k),  32'(r5_vld),  32'd1);
      chk($sformatf("r5_idx_%0d", k),  32'(r5_idx),  (k % 2 == 1) ? 32'd4 : 32'd0);
      chk($sformatf("r5_oh_%0d", k),   32'(r5_oh),   (k % 2 == 1) ? 32'h10 : 32'h01);
      chk($sformatf("r5_ptr_%0d", k),  32'(r5_ptr),  (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("r5_range_%0d", k), 32'(r5_idx <= 3'd4), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Registered N-way request arbiter. Generalises the codebase's combinational priority encoder.
- Selectable mode: fixed MSB priority, fixed LSB priority, or round-robin.
- Grant is presented on a valid/ready handshake and held stable until accepted.
- Sits between multiple requesters (e.g. SPI/peripheral command sources) and a single shared consumer.

Parameters:
- N_REQ, 8, number of request lines; any value >= 2, power of 2 not required.
- MODE, ARB_ROUND_ROBIN, arbitration policy of type arb_mode_t: ARB_FIXED_MSB, ARB_FIXED_LSB or ARB_ROUND_ROBIN.
- IDX_W, max(1,$clog2(N_REQ)), derived localparam, not user-set.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  request vector; bit i = requester i.
- gnt_valid  output  1  a grant is being presented.
- gnt_ready  input  1  consumer accepts the presented grant this cycle.
- gnt_idx  output  IDX_W  index of the granted requester.
- gnt_onehot  output  N_REQ  one-hot form of gnt_idx; all zero when gnt_valid=0.
- rr_ptr  output  IDX_W  current round-robin start index, for debug; reads 0 in fixed modes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr_ptr=0.
- States:
  - IDLE: no grant held.
  - GRANT: grant registered and presented.
- Winner selection (combinational, from current req):
  - ARB_FIXED_MSB: highest set bit wins.
  - ARB_FIXED_LSB: lowest set bit wins.
  - ARB_ROUND_ROBIN: first set bit at or after rr_ptr, searching ascending and wrapping from N_REQ-1 to 0.
- IDLE -> GRANT: when req!=0, the winner is registered and gnt_valid=1 on the next edge. Latency is 1 cycle from req to gnt_valid.
- GRANT with gnt_ready=0: gnt_idx and gnt_onehot hold stable, even if req[gnt_idx] drops or a higher-priority req appears. No revocation.
- GRANT with gnt_ready=1 (handshake):
  - ARB_ROUND_ROBIN: rr_ptr <= (gnt_idx==N_REQ-1) ? 0 : gnt_idx+1.
  - The same edge arbitrates again for back-to-back grants. Selection uses the current req and the pre-update rr_ptr, except the just-accepted index is excluded in ARB_ROUND_ROBIN.
  - If any eligible req is present: stay in GRANT with the new winner. Otherwise go to IDLE with gnt_valid=0.
  - Throughput: 1 grant per cycle.
- Fixed modes may re-grant the same index back-to-back if its req is still asserted. This is intended.
- gnt_ready while gnt_valid=0 is ignored.
- req=0 in IDLE: remain IDLE; outputs unchanged except gnt_onehot=0.
- N_REQ not a power of 2: indices >= N_REQ are never produced, and rr_ptr wraps at N_REQ-1.
- Reset mid-grant: the grant is dropped immediately (async) and rr_ptr returns to 0. No handshake completes.
- Round-robin fairness: with all bits requesting continuously and gnt_ready=1, each index is granted exactly once per N_REQ consecutive grants.

Decomposition:
- Package arb_pkg:
  - arb_mode_t enum {ARB_FIXED_MSB, ARB_FIXED_LSB, ARB_ROUND_ROBIN}.
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
- Sub-module rr_pick: purely combinational. Inputs: req, start index, exclude mask. Outputs: idx and found.
  - Implemented as double-width masked priority search (req & ~mask_below_start, then unmasked fallback).
  - Fixed modes reuse it with start=0 (LSB) or with a bit-reversed vector (MSB).
- Top level holds the FSM, grant registers and rr_ptr.

Test Plan:
- Reset: hold reset_n=0 with req=8'hFF -> gnt_valid=0, gnt_onehot=0, rr_ptr=0. Deassert: gnt_valid=1 one cycle later with gnt_idx=0 (RR).
- Hold stability: RR, req=8'b0000_0100, gnt_ready=0 for 5 cycles, then switch req to 8'h80 -> gnt_idx stays 2 until gnt_ready=1. Next grant is 7.
- RR fairness and wrap: req=8'hFF, gnt_ready=1 continuously -> gnt_idx sequence 0,1,...,7,0,1 with no bubbles. rr_ptr wraps 7->0.
- Fixed modes: req=8'b0101_0010 -> ARB_FIXED_MSB grants 6 repeatedly; ARB_FIXED_LSB grants 1 repeatedly, back-to-back with gnt_ready=1.
- Non-power-of-2: N_REQ=5, req=5'b10001, RR -> grants 0,4,0,4. gnt_idx is never >4.
- Async reset mid-grant: assert reset_n=0 between clock edges while gnt_valid=1 and gnt_idx=3 -> gnt_valid falls without waiting for a clock edge. After release, rr_ptr=0.
